// File: rtl/lsu_timeout_if.sv
// Data-memory channel between one thread's LSU and the memory controller.
// The LSU is the master: it raises a request and waits for the ready pulse.
interface lsu_timeout_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) ();
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/lsu_timeout.sv
// Per-thread load/store unit with a response-timeout watchdog.
// Executes one LDR or STR per instruction over a valid/ready memory channel,
// aborts with a sticky error if the response does not arrive in time, and
// flags simultaneous read+write requests as illegal without touching memory.
module lsu_timeout #(
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERROR_VALUE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  lsu_timeout_if.master        mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam logic [2:0] CORE_REQUEST = 3'd3;
  localparam logic [2:0] CORE_UPDATE  = 3'd6;

  // Counter only needs to reach TIMEOUT_CYCLES-1; with the watchdog off it
  // simply wraps and is never compared.
  localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [DATA_BITS-1:0] ERR_DATA = DATA_BITS'(ERROR_VALUE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUESTING = 2'd1,
    WAITING    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t               state_r;
  logic                 op_read_r;
  logic [CNT_BITS-1:0]  count_r;
  logic                 read_valid_r;
  logic [ADDR_BITS-1:0] read_addr_r;
  logic                 write_valid_r;
  logic [ADDR_BITS-1:0] write_addr_r;
  logic [DATA_BITS-1:0] write_data_r;
  logic [DATA_BITS-1:0] out_r;
  logic                 error_r;

  logic ready_s;
  logic timeout_hit_s;

  // Select the ready of the latched operation and detect the last allowed wait cycle.
  always_comb begin
    ready_s       = 1'b0;
    timeout_hit_s = 1'b0;
    if (op_read_r) begin
      ready_s = mem.mem_read_ready;
    end else begin
      ready_s = mem.mem_write_ready;
    end
    if (TIMEOUT_EN && (count_r == CNT_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      op_read_r     <= 1'b0;
      count_r       <= '0;
      read_valid_r  <= 1'b0;
      read_addr_r   <= '0;
      write_valid_r <= 1'b0;
      write_addr_r  <= '0;
      write_data_r  <= '0;
      out_r         <= '0;
      error_r       <= 1'b0;
    end else if (enable) begin
      case (state_r)
        IDLE: begin
          if (core_state == CORE_REQUEST) begin
            if (decoded_mem_read_enable && decoded_mem_write_enable) begin
              error_r <= 1'b1;
              state_r <= DONE;
            end else if (decoded_mem_read_enable ^ decoded_mem_write_enable) begin
              op_read_r <= decoded_mem_read_enable;
              state_r   <= REQUESTING;
            end
          end
        end
        REQUESTING: begin
          if (op_read_r) begin
            read_valid_r <= 1'b1;
            read_addr_r  <= ADDR_BITS'(rs);
          end else begin
            write_valid_r <= 1'b1;
            write_addr_r  <= ADDR_BITS'(rs);
            write_data_r  <= rt;
          end
          count_r <= '0;
          state_r <= WAITING;
        end
        WAITING: begin
          // A ready on the final allowed cycle still completes normally.
          if (ready_s) begin
            if (op_read_r) begin
              out_r <= mem.mem_read_data;
            end
            read_valid_r  <= 1'b0;
            write_valid_r <= 1'b0;
            state_r       <= DONE;
          end else if (timeout_hit_s) begin
            if (op_read_r) begin
              out_r <= ERR_DATA;
            end
            read_valid_r  <= 1'b0;
            write_valid_r <= 1'b0;
            error_r       <= 1'b1;
            state_r       <= DONE;
          end else begin
            count_r <= count_r + CNT_BITS'(1);
          end
        end
        DONE: begin
          if (core_state == CORE_UPDATE) begin
            error_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          read_valid_r  <= 1'b0;
          write_valid_r <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_read_valid    = read_valid_r;
  assign mem.mem_read_address  = read_addr_r;
  assign mem.mem_write_valid   = write_valid_r;
  assign mem.mem_write_address = write_addr_r;
  assign mem.mem_write_data    = write_data_r;
  assign lsu_state             = state_r;
  assign lsu_out               = out_r;
  assign lsu_error             = error_r;

endmodule

// File: doc/lsu_timeout.md
Name: lsu_timeout

Overview:
Parametrised per-thread load-store unit, the successor to the fixed 8-bit LSU. It executes LDR/STR for one thread against a data-memory channel using a valid/ready handshake. It adds configurable address and data widths and a response-timeout watchdog with an error flag. It adds a defined illegal-operation rule for read and write requested together. One instance sits per thread per core, between the register file and the memory controller.

Parameters:
DATA_BITS, 8, register/memory data width
ADDR_BITS, 8, memory address width; address = rs truncated or zero-extended to ADDR_BITS
TIMEOUT_CYCLES, 64, max cycles in WAITING before abort; 0 disables the watchdog
ERROR_VALUE, 0, value loaded into lsu_out on read timeout (truncated to DATA_BITS)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  thread active; when low, all state and outputs hold
core_state  input  3  core FSM state; REQUEST=3'd3, UPDATE=3'd6
decoded_mem_read_enable  input  1  LDR in flight
decoded_mem_write_enable  input  1  STR in flight
rs  input  DATA_BITS  address operand
rt  input  DATA_BITS  store data
mem_read_valid  output  1  read request
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  read response valid
mem_read_data  input  DATA_BITS  read data
mem_write_valid  output  1  write request
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data
mem_write_ready  input  1  write acknowledged
lsu_state  output  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3
lsu_out  output  DATA_BITS  loaded data
lsu_error  output  1  sticky error for current instruction

Behaviour:
- Single clock; all registers update on posedge clk. Reset is synchronous and active-high. Reset has priority over enable.
- Reset values: lsu_state=IDLE, lsu_out=0, lsu_error=0, all valids=0, addresses=0, write_data=0, wait counter=0.
- Reset mid-transaction: valid drops on the next edge; no response is awaited afterwards.
- op = read if decoded_mem_read_enable, write if decoded_mem_write_enable. Op is latched on IDLE->REQUESTING.
- IDLE: if enable and core_state==REQUEST and exactly one enable is set -> REQUESTING.
- IDLE, both enables set at REQUEST: go directly to DONE with lsu_error=1. No memory request is issued; lsu_out is unchanged.
- IDLE, neither enable set: stay IDLE.
- REQUESTING (1 cycle):
  - read: mem_read_valid<=1, mem_read_address<=rs[ADDR_BITS-1:0].
  - write: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt.
  - Counter<=0; -> WAITING.
- WAITING:
  - Valid stays high and address/data stay stable until the handshake completes.
  - read: on mem_read_ready, lsu_out<=mem_read_data, mem_read_valid<=0 -> DONE.
  - write: on mem_write_ready, mem_write_valid<=0 -> DONE.
  - Otherwise counter increments.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ready: drop valid, lsu_error<=1, lsu_out<=ERROR_VALUE if read -> DONE.
  - Ready arriving on the timeout cycle wins: normal completion, no error.
  - Ready on the same cycle valid rises (the REQUESTING edge) is ignored; it is sampled only in WAITING.
- DONE: hold lsu_out and lsu_error. On core_state==UPDATE -> IDLE and lsu_error<=0 (lsu_out retained).
- enable low: full freeze, including the wait counter. Valid stays as registered.
- Minimum load latency: REQUEST seen -> DONE in 3 cycles when ready is returned on the first WAITING cycle.

Test Plan:
- Load: DATA_BITS=8, rs=0x2A, read_enable, core_state=REQUEST; memory returns 0x5C after 2 WAITING cycles -> read_valid high with addr 0x2A; lsu_out=0x5C; lsu_state=DONE; lsu_error=0; IDLE after UPDATE.
- Store: DATA_BITS=16, ADDR_BITS=10, rs=0x03FF, rt=0xBEEF; write_ready after 1 cycle -> write_address=0x3FF, write_data=0xBEEF held stable until ready; write_valid drops; DONE.
- Timeout: TIMEOUT_CYCLES=4, ERROR_VALUE=0xEE, read with ready never asserted -> valid drops after exactly 4 WAITING cycles; lsu_out=0xEE; lsu_error=1; error clears on UPDATE.
- Ready at the timeout boundary: ready asserted on the 4th WAITING cycle with data 0x11 -> lsu_out=0x11, lsu_error=0.
- Illegal op: both enables at REQUEST -> DONE next cycle; lsu_error=1; no valid ever asserted.
- Reset and freeze: reset asserted during WAITING -> next edge all outputs at reset values. Separately, enable=0 for 10 cycles mid-WAIT with TIMEOUT_CYCLES=4 -> no timeout, state held.
